// File: rtl/global_pkg.sv
// Shared types for the ALU and its command sequencer: micro-op codes, command codes,
// sequencer states and the command-to-micro-op mapping.
package global_pkg;

  typedef enum logic [3:0] {
    nop      = 4'd0,
    op_lda   = 4'd1,
    op_ldb   = 4'd2,
    op_add   = 4'd3,
    op_sub   = 4'd4,
    op_and   = 4'd5,
    op_or    = 4'd6,
    op_xor   = 4'd7,
    op_oeacc = 4'd8
  } alu_op;

  typedef enum logic [2:0] {
    CMD_ADD = 3'd0,
    CMD_SUB = 3'd1,
    CMD_AND = 3'd2,
    CMD_OR  = 3'd3,
    CMD_XOR = 3'd4
  } alu_cmd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDA   = 3'd1,
    LDB   = 3'd2,
    EXEC  = 3'd3,
    OEACC = 3'd4,
    RESP  = 3'd5
  } seq_state_t;

  function automatic logic cmd_legal(alu_cmd_t c);
    return c <= CMD_XOR;
  endfunction

  function automatic alu_op cmd_to_op(alu_cmd_t c);
    case (c)
      CMD_ADD: return op_add;
      CMD_SUB: return op_sub;
      CMD_AND: return op_and;
      CMD_OR:  return op_or;
      CMD_XOR: return op_xor;
      default: return nop;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command request / response channels between the control unit and alu_sequencer.
interface alu_sequencer_if;

  logic                 Req_Valid;
  logic                 Req_Ready;
  global_pkg::alu_cmd_t Req_Cmd;
  logic [7:0]           Req_A;
  logic [7:0]           Req_B;
  logic                 Rsp_Valid;
  logic                 Rsp_Ready;
  logic [7:0]           Rsp_Data;
  logic                 Rsp_FlagZ;
  logic                 Rsp_FlagC;
  logic                 Rsp_FlagN;
  logic                 Rsp_FlagE;
  logic                 Rsp_Err;

  modport master (
    output Req_Valid, Req_Cmd, Req_A, Req_B, Rsp_Ready,
    input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_FlagZ, Rsp_FlagC, Rsp_FlagN, Rsp_FlagE, Rsp_Err
  );

  modport slave (
    input  Req_Valid, Req_Cmd, Req_A, Req_B, Rsp_Ready,
    output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_FlagZ, Rsp_FlagC, Rsp_FlagN, Rsp_FlagE, Rsp_Err
  );

endinterface

// File: rtl/alu.sv
// 8-bit accumulator ALU: A/B load registers, operation into ACC with flags, ACC to OutData on op_oeacc.
module alu
  import global_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst_n,
  input  alu_op      ALU_op,
  input  logic [7:0] InData,
  output logic [7:0] OutData,
  output logic       FlagZ,
  output logic       FlagC,
  output logic       FlagN,
  output logic       FlagE
);

  logic [7:0] a_r, b_r, acc_r;
  logic [8:0] res;

  // Bit 8 is carry-out for add and borrow for sub.
  always_comb begin
    res = {1'b0, acc_r};
    case (ALU_op)
      op_add:  res = {1'b0, a_r} + {1'b0, b_r};
      op_sub:  res = {1'b0, a_r} - {1'b0, b_r};
      op_and:  res = {1'b0, a_r & b_r};
      op_or:   res = {1'b0, a_r | b_r};
      op_xor:  res = {1'b0, a_r ^ b_r};
      default: res = {1'b0, acc_r};
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      OutData <= '0;
      FlagZ   <= 1'b0;
      FlagC   <= 1'b0;
      FlagN   <= 1'b0;
      FlagE   <= 1'b0;
    end else begin
      case (ALU_op)
        op_lda: a_r <= InData;
        op_ldb: b_r <= InData;
        op_add, op_sub, op_and, op_or, op_xor: begin
          acc_r <= res[7:0];
          FlagZ <= (res[7:0] == 8'h00);
          FlagC <= res[8];
          FlagN <= res[7];
          FlagE <= (a_r == b_r);
        end
        op_oeacc: OutData <= acc_r;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Accepts one two-operand command, drives the lda/ldb/op/oeacc micro-sequence into alu,
// and returns the captured result and flags over a valid/ready response channel.
module alu_sequencer
  import global_pkg::*;
#(
  parameter int OP_CYCLES = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  alu_sequencer_if.slave bus,
  output alu_op         ALU_op,
  output logic [7:0]    InData,
  input  logic [7:0]    OutData,
  input  logic          FlagZ,
  input  logic          FlagC,
  input  logic          FlagN,
  input  logic          FlagE
);

  localparam int CW = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;
  localparam logic [CW-1:0] PH_LAST = CW'(OP_CYCLES - 1);

  if (OP_CYCLES < 2 || OP_CYCLES > 15) begin : g_bad_op_cycles
    $error("alu_sequencer: OP_CYCLES must be within 2..15");
  end

  seq_state_t    state, state_nxt;
  logic [CW-1:0] ph, ph_nxt;
  alu_cmd_t      cmd_q;
  logic [7:0]    a_q, b_q;
  alu_op         op_nxt;
  logic [7:0]    data_nxt;
  logic          rsp_vld_nxt;
  logic          accept, ph_done, timed;

  assign accept  = (state == IDLE) && bus.Req_Ready && bus.Req_Valid;
  assign ph_done = (ph == PH_LAST);
  assign timed   = state inside {LDA, LDB, EXEC, OEACC};

  // Outputs are registered from the next-state decode so they line up with the state register.
  always_comb begin
    state_nxt   = state;
    ph_nxt      = '0;
    op_nxt      = nop;
    data_nxt    = '0;
    rsp_vld_nxt = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = cmd_legal(bus.Req_Cmd) ? LDA : RESP;
      LDA:     if (ph_done) state_nxt = LDB;
      LDB:     if (ph_done) state_nxt = EXEC;
      EXEC:    if (ph_done) state_nxt = OEACC;
      OEACC:   if (ph_done) state_nxt = RESP;
      RESP:    if (bus.Rsp_Valid && bus.Rsp_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timed && state_nxt == state) ph_nxt = ph + CW'(1);
    case (state_nxt)
      LDA: begin
        op_nxt   = op_lda;
        data_nxt = accept ? bus.Req_A : a_q;
      end
      LDB: begin
        op_nxt   = op_ldb;
        data_nxt = b_q;
      end
      EXEC:  op_nxt = cmd_to_op(cmd_q);
      OEACC: op_nxt = op_oeacc;
      // An illegal command enters RESP at accept; its valid follows one cycle later.
      RESP:  rsp_vld_nxt = !accept;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      ph            <= '0;
      ALU_op        <= nop;
      InData        <= '0;
      bus.Req_Ready <= 1'b0;
      bus.Rsp_Valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      ph            <= ph_nxt;
      ALU_op        <= op_nxt;
      InData        <= data_nxt;
      bus.Req_Ready <= (state_nxt == IDLE);
      bus.Rsp_Valid <= rsp_vld_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cmd_q         <= CMD_ADD;
      a_q           <= '0;
      b_q           <= '0;
      bus.Rsp_Data  <= '0;
      bus.Rsp_FlagZ <= 1'b0;
      bus.Rsp_FlagC <= 1'b0;
      bus.Rsp_FlagN <= 1'b0;
      bus.Rsp_FlagE <= 1'b0;
      bus.Rsp_Err   <= 1'b0;
    end else if (accept) begin
      cmd_q <= bus.Req_Cmd;
      a_q   <= bus.Req_A;
      b_q   <= bus.Req_B;
      if (!cmd_legal(bus.Req_Cmd)) begin
        bus.Rsp_Data  <= '0;
        bus.Rsp_FlagZ <= 1'b0;
        bus.Rsp_FlagC <= 1'b0;
        bus.Rsp_FlagN <= 1'b0;
        bus.Rsp_FlagE <= 1'b0;
        bus.Rsp_Err   <= 1'b1;
      end
    end else if (state == OEACC && ph_done) begin
      bus.Rsp_Data  <= OutData;
      bus.Rsp_FlagZ <= FlagZ;
      bus.Rsp_FlagC <= FlagC;
      bus.Rsp_FlagN <= FlagN;
      bus.Rsp_FlagE <= FlagE;
      bus.Rsp_Err   <= 1'b0;
    end
  end

endmodule
